// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined carry-lookahead subtractor (d = a - b - bin) with valid/ready on both sides.
// Optional saturating mode under `CLA_SUB_SAT_EN: a borrowing result loads d = 0.
module cla_sub_pipe #(
    parameter int unsigned NBIT = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [NBIT-1:0] a,
    input  logic [NBIT-1:0] b,
    input  logic            bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NBIT-1:0] d,
    output logic            bout,
    output logic            busy
);

    localparam int unsigned LO_W = NBIT / 2;
    localparam int unsigned HI_W = NBIT - LO_W;

    logic            s1_valid;
    logic [LO_W-1:0] s1_d_lo;
    logic            s1_c;
    logic [HI_W-1:0] s1_a_hi;
    logic [HI_W-1:0] s1_nb_hi;
    logic            s2_valid;

    logic            s1_load;
    logic            s2_load;

    // Handshake: stage 2 takes stage 1 whenever its slot is empty or draining.
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign s1_load   = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign busy      = s1_valid | s2_valid;

    // Low half: a + ~b + ~bin via generate/propagate ripple of lookahead terms.
    logic [LO_W-1:0] nb_lo;
    logic [LO_W-1:0] g_lo;
    logic [LO_W-1:0] p_lo;
    logic [LO_W-1:0] sum_lo;
    logic [LO_W:0]   c_lo;

    always_comb begin
        nb_lo   = ~b[LO_W-1:0];
        g_lo    = a[LO_W-1:0] & nb_lo;
        p_lo    = a[LO_W-1:0] ^ nb_lo;
        c_lo    = '0;
        c_lo[0] = ~bin;
        for (int unsigned i = 0; i < LO_W; i++) begin
            c_lo[i+1] = g_lo[i] | (p_lo[i] & c_lo[i]);
        end
        sum_lo = p_lo ^ c_lo[LO_W-1:0];
    end

    // High half from registered operands and the registered inter-half carry.
    logic [HI_W-1:0] g_hi;
    logic [HI_W-1:0] p_hi;
    logic [HI_W-1:0] sum_hi;
    logic [HI_W:0]   c_hi;
    logic            borrow;
    logic [NBIT-1:0] d_next;

    always_comb begin
        g_hi    = s1_a_hi & s1_nb_hi;
        p_hi    = s1_a_hi ^ s1_nb_hi;
        c_hi    = '0;
        c_hi[0] = s1_c;
        for (int unsigned i = 0; i < HI_W; i++) begin
            c_hi[i+1] = g_hi[i] | (p_hi[i] & c_hi[i]);
        end
        sum_hi = p_hi ^ c_hi[HI_W-1:0];
        borrow = ~c_hi[HI_W];
`ifdef CLA_SUB_SAT_EN
        d_next = borrow ? '0 : {sum_hi, s1_d_lo};
`else
        d_next = {sum_hi, s1_d_lo};
`endif
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_d_lo  <= '0;
            s1_c     <= 1'b0;
            s1_a_hi  <= '0;
            s1_nb_hi <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_d_lo  <= sum_lo;
            s1_c     <= c_lo[LO_W];
            s1_a_hi  <= a[NBIT-1:LO_W];
            s1_nb_hi <= ~b[NBIT-1:LO_W];
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 registers drive the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            d        <= '0;
            bout     <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            d        <= d_next;
            bout     <= borrow;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed testbench for cla_sub_pipe (NBIT=7): latency, boundaries, streaming, stall, async reset.
module tb_cla_sub_pipe;

    localparam int unsigned NBIT = 7;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            bin;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] d;
    logic            bout;
    logic            busy;

    cla_sub_pipe #(.NBIT(NBIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int fire_cnt = 0;
    logic [NBIT:0] exp_q[$];
    logic [NBIT:0] cur_exp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: record accepts, score fired results, advance to the next falling edge.
    task automatic step(input string tag);
        logic [NBIT:0] e;
        #1;
        if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            fire_cnt++;
            if (exp_q.size() == 0) begin
                chk({tag, "_spurious"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_d"}, 32'(d), 32'(e[NBIT-1:0]));
                chk({tag, "_bout"}, 32'(bout), 32'(e[NBIT]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_beat(input int av, input int bv, input logic bi, input int ed, input logic eb);
        in_valid = 1'b1;
        a        = NBIT'(av);
        b        = NBIT'(bv);
        bin      = bi;
        cur_exp  = {eb, NBIT'(ed)};
    endtask

    // Directed single-beat vectors: a, b, bin, expected d, expected bout.
    int vec_a[6]  = '{100, 5, 0, 127, 127, 64};
    int vec_b[6]  = '{37, 9, 0, 127, 0, 1};
    int vec_bi[6] = '{0, 0, 1, 0, 0, 0};
`ifdef CLA_SUB_SAT_EN
    int vec_d[6]  = '{63, 0, 0, 0, 127, 63};
`else
    int vec_d[6]  = '{63, 124, 127, 0, 127, 63};
`endif
    int vec_bo[6] = '{0, 1, 1, 0, 0, 0};

    int stall_a[3] = '{10, 20, 30};
    int stall_b[3] = '{3, 5, 7};
    int stall_d[3] = '{7, 15, 23};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        cur_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_d", 32'(d), 0);
        chk("rst_bout", 32'(bout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);

        // Single beats with exact two-cycle latency.
        for (int v = 0; v < 6; v++) begin
            set_beat(vec_a[v], vec_b[v], vec_bi[v][0], vec_d[v], vec_bo[v][0]);
            step("vec_acc");
            in_valid = 1'b0;
            chk($sformatf("vec%0d_lat1_ov", v), 32'(out_valid), 0);
            chk($sformatf("vec%0d_lat1_busy", v), 32'(busy), 1);
            step("vec_mid");
            chk($sformatf("vec%0d_lat2_ov", v), 32'(out_valid), 1);
            step($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_idle_busy", v), 32'(busy), 0);
        end

        // Back-to-back stream: one result per cycle, in_ready held high.
        fire_cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            set_beat(i, 1, 1'b0, i - 1, 1'b0);
            #1;
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 1);
            step("stream");
        end
        in_valid = 1'b0;
        repeat (3) step("stream_drain");
        chk("stream_fired", 32'(fire_cnt), 20);
        chk("stream_empty", 32'(exp_q.size()), 0);

        // Stall with out_ready low: two beats buffered, third held off.
        out_ready = 1'b0;
        acc_cnt   = 0;
        fire_cnt  = 0;
        for (int c = 0; c < 6; c++) begin
            set_beat(stall_a[acc_cnt], stall_b[acc_cnt], 1'b0, stall_d[acc_cnt], 1'b0);
            step("stall");
            if (c >= 2) chk($sformatf("stall%0d_d_stable", c), 32'(d), 7);
        end
        chk("stall_accepted", 32'(acc_cnt), 2);
        #1;
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (acc_cnt < 3) set_beat(stall_a[acc_cnt], stall_b[acc_cnt], 1'b0, stall_d[acc_cnt], 1'b0);
            else in_valid = 1'b0;
            step("release");
        end
        chk("release_fired", 32'(fire_cnt), 3);
        chk("release_empty", 32'(exp_q.size()), 0);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_beat(50 + c, 1, 1'b0, 49 + c, 1'b0);
            step("prefill");
        end
        in_valid = 1'b0;
        chk("full_busy", 32'(busy), 1);
        chk("full_out_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_d", 32'(d), 0);
        chk("arst_bout", 32'(bout), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        fire_cnt  = 0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("post_rst%0d_ov", c), 32'(out_valid), 0);
            step("post_rst");
        end
        chk("post_rst_fired", 32'(fire_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_sub_pipe.md
Name: cla_sub_pipe

Overview:
- Two-stage pipelined carry-lookahead subtractor: d = a - b - bin, modulo 2^NBIT, with borrow out.
- Arithmetic counterpart to the team's combinational CLA adder. Used where subtraction must meet timing at wide NBIT.
- The datapath is split into low and high halves, one half per stage, with the inter-half borrow registered.
- Valid/ready handshakes on both sides so it drops into streaming datapaths.

Parameters:
- NBIT, 7, operand and result width; legal range 2 and up.
- LO_W, NBIT/2 (integer division), width of the low half computed in stage 1; HI_W = NBIT - LO_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts a beat this cycle
- a  input  NBIT  minuend, unsigned
- b  input  NBIT  subtrahend, unsigned
- bin  input  1  borrow in
- out_valid  output  1  result beat present
- out_ready  input  1  downstream accepts result
- d  output  NBIT  difference
- bout  output  1  borrow out; 1 when a < b + bin
- busy  output  1  either pipeline stage holds a beat

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0: s1_valid=0, s2_valid=0, out_valid=0, d=0, bout=0, busy=0, and all stage registers are 0.
- Reset mid-operation discards in-flight beats. No result is emitted for them.
- Subtraction is computed as a + ~b + ~bin using CLA generate/propagate: g = a & ~b, p = a ^ ~b, c0 = ~bin, c[i+1] = g[i] | (p[i] & c[i]). bout = ~carry_out.
- Stage 1, on accept (in_valid & in_ready):
  - register d_lo = low LO_W bits of the result;
  - register the carry out of bit LO_W-1;
  - register a[NBIT-1:LO_W] and ~b[NBIT-1:LO_W];
  - set s1_valid.
- Stage 2: computes the HI_W upper bits from the registered operands and registered carry. It registers d = {d_hi, d_lo} and bout, and sets s2_valid.
- out_valid = s2_valid. d and bout are driven directly from stage-2 registers, with no combinational path from inputs.
- Advance rules:
  - s2_load = s1_valid & (!s2_valid | out_ready)
  - s1_load = in_valid & in_ready
  - in_ready = !s1_valid | s2_load (combinational from out_ready; no path from in_valid)
- Clearing: s1_valid clears when s2_load & !s1_load. s2_valid clears when out_ready & !s2_load.
- Latency is 2 cycles from accept to out_valid when unstalled.
- Throughput is 1 beat/cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0, the d/bout registers are held stable, at most 2 beats are buffered, and in_ready=0 once both stages are full.
- Simultaneous accept, transfer and drain in one cycle is legal. No beat is lost or duplicated.
- Ordering is strictly FIFO.
- busy = s1_valid | s2_valid.
- Boundary cases:
  - a=b, bin=0 → d=0, bout=0.
  - a=0, b=0, bin=1 → d=all ones, bout=1.
  - a=all ones, b=0 → d=a, bout=0.

Optional Feature:
- Macro: CLA_SUB_SAT_EN
- Defined: saturating unsigned mode. When the final borrow is 1, stage 2 loads d=0; bout still reports 1. Latency is unchanged.
- Undefined: d wraps modulo 2^NBIT. No saturation logic is present.

Test Plan:
- Reset, then a=100, b=37, bin=0, out_ready=1 → two cycles after accept: out_valid=1, d=63, bout=0.
- a=5, b=9, bin=0 → d=124, bout=1. With CLA_SUB_SAT_EN: d=0, bout=1.
- a=0, b=0, bin=1 → d=127, bout=1. Then a=127, b=127, bin=0 → d=0, bout=0. Checks the low/high carry crossing at bit LO_W=3.
- Back-to-back stream a=i, b=1, i=1..20, out_ready=1 → one result per cycle d=i-1, in order, in_ready held 1.
- Hold out_ready=0 while streaming 3 beats → 2 accepted, in_ready=0, d stable. Release out_ready → remaining beats drain in order with no loss or duplication.
- Assert rst_n=0 with both stages full → out_valid, busy, d, bout go 0 immediately (async). After release, no stale beat appears.
